// File: rtl/i2c_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : i2c_req_arbiter
// Purpose  : Round-robin arbiter and transaction sequencer sharing one I2C
//            master controller among N_REQ requesters. The winning requester's
//            descriptor (direction, address, byte count) is latched. The master
//            is then launched with a held enable. A done pulse (or an err pulse
//            on timeout) is returned to the granted requester.
// Ports    : clk, rst_n (async, active low)
//            req/req_rw/req_addr/req_nbyte : per-requester request + descriptor
//            gnt/done/err                  : per-requester grant and result pulses
//            busy                          : FSM not in IDLE
//            m_ena/m_rw/m_addr/m_nbyte     : registered command to the I2C master
//            m_valid/m_state               : completion flag and state from master
// Options  : I2C_ARB_TIMEOUT_EN - when defined, a launch-to-completion watchdog
//            of TIMEOUT cycles aborts the transaction with an err pulse.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_req_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 4095
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   req_rw,
  input  logic [7*N_REQ-1:0] req_addr,
  input  logic [5*N_REQ-1:0] req_nbyte,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic [N_REQ-1:0]   err,
  output logic               busy,
  output logic               m_ena,
  output logic               m_rw,
  output logic [6:0]         m_addr,
  output logic [4:0]         m_nbyte,
  input  logic               m_valid,
  input  logic [3:0]         m_state
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_LAUNCH  = 2'd1;
  localparam logic [1:0] c_WAIT    = 2'd2;
  localparam logic [1:0] c_RELEASE = 2'd3;

  logic [1:0]    r_state;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] r_gidx;

  logic          w_found;
  logic [PW-1:0] w_sel;
  logic [PW:0]   w_sum;
  logic [PW-1:0] w_nxt_ptr;
  logic          w_tmo;
  logic          w_master_idle;

  assign w_master_idle = (m_state == 4'd0);

  // Pointer-priority search: walk offsets 0..N_REQ-1 from r_ptr, wrapping
  // at N_REQ (not at 2**PW), and take the first requester found.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_sum   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(N_REQ)) begin
        w_sum = w_sum - (PW+1)'(N_REQ);
      end
      if (!w_found && req[w_sum[PW-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_sum[PW-1:0];
      end
    end
  end

  // Next pointer: one past the requester just served, modulo N_REQ.
  assign w_nxt_ptr = (r_gidx == PW'(N_REQ-1)) ? '0 : r_gidx + PW'(1);

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT+1);

  logic [CW-1:0] r_cnt;

  // Counts cycles since grant; saturates at TIMEOUT so the abort condition
  // holds until the FSM acts on it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state == c_IDLE) begin
      r_cnt <= '0;
    end else if ((r_state == c_LAUNCH || r_state == c_WAIT) &&
                 (r_cnt != CW'(TIMEOUT))) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign w_tmo = (r_cnt == CW'(TIMEOUT));
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_ptr   <= '0;
      r_gidx  <= '0;
      gnt     <= '0;
      done    <= '0;
      err     <= '0;
      busy    <= 1'b0;
      m_ena   <= 1'b0;
      m_rw    <= 1'b0;
      m_addr  <= '0;
      m_nbyte <= '0;
    end else begin
      done <= '0;
      err  <= '0;
      case (r_state)
        c_IDLE: begin
          if (w_found && w_master_idle) begin
            gnt     <= N_REQ'(1) << w_sel;
            r_gidx  <= w_sel;
            m_rw    <= req_rw[w_sel];
            m_addr  <= req_addr[w_sel*7 +: 7];
            m_nbyte <= req_nbyte[w_sel*5 +: 5];
            m_ena   <= 1'b1;
            busy    <= 1'b1;
            r_state <= c_LAUNCH;
          end
        end
        c_LAUNCH: begin
          // m_valid is not looked at here; only a timeout can abort launch.
          if (w_tmo) begin
            err     <= gnt;
            gnt     <= '0;
            m_ena   <= 1'b0;
            r_ptr   <= w_nxt_ptr;
            r_state <= c_RELEASE;
          end else if (!w_master_idle) begin
            m_ena   <= 1'b0;
            r_state <= c_WAIT;
          end
        end
        c_WAIT: begin
          // Completion takes precedence over a coincident timeout.
          if (m_valid) begin
            done    <= gnt;
            gnt     <= '0;
            r_ptr   <= w_nxt_ptr;
            r_state <= c_RELEASE;
          end else if (w_tmo) begin
            err     <= gnt;
            gnt     <= '0;
            r_ptr   <= w_nxt_ptr;
            r_state <= c_RELEASE;
          end
        end
        c_RELEASE: begin
          if (w_master_idle) begin
            busy    <= 1'b0;
            r_state <= c_IDLE;
          end
        end
        default: begin
          r_state <= c_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_req_arbiter
// Purpose  : Directed self-checking bench for i2c_req_arbiter. The bench acts
//            as the I2C master by driving m_state/m_valid by hand.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_req_arbiter;

  localparam int TB_TO = 100;
`ifdef I2C_ARB_TIMEOUT_EN
  localparam int WAIT_CYC = 50;
`else
  localparam int WAIT_CYC = 200;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  req_rw = '0;
  logic [27:0] req_addr = '0;
  logic [19:0] req_nbyte = '0;
  logic        m_valid = 1'b0;
  logic [3:0]  m_state = '0;
  logic [3:0]  gnt, done, err;
  logic        busy, m_ena, m_rw;
  logic [6:0]  m_addr;
  logic [4:0]  m_nbyte;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int err_seen = 0;
  int last_done = -100;

  i2c_req_arbiter #(.N_REQ(4), .TIMEOUT(TB_TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_rw(req_rw),
    .req_addr(req_addr), .req_nbyte(req_nbyte), .gnt(gnt), .done(done),
    .err(err), .busy(busy), .m_ena(m_ena), .m_rw(m_rw), .m_addr(m_addr),
    .m_nbyte(m_nbyte), .m_valid(m_valid), .m_state(m_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (err !== 4'b0) err_seen++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Generic transaction: wait for grant, play master, complete with m_valid
  // held vlen cycles, and check one done pulse to the expected requester.
  task automatic run_txn(input logic [3:0] exp, input int vlen,
                         input logic [3:0] req_after, input string name);
    int n;
    int dones;
    n = 0;
    while (gnt === 4'b0 && n < 20) begin tick(); n++; end
    n_chk++;
    if (gnt !== exp) begin
      n_fail++; $display("FAIL %s_gnt: got %b expected %b", name, gnt, exp);
    end
    n_chk++;
    if (!$onehot(gnt)) begin
      n_fail++; $display("FAIL %s_onehot: got %b expected one-hot", name, gnt);
    end
    m_state = 4'd1;
    n = 0;
    while (m_ena !== 1'b0 && n < 20) begin tick(); n++; end
    n_chk++;
    if (m_ena !== 1'b0) begin
      n_fail++; $display("FAIL %s_ena_drop: got %b expected 0", name, m_ena);
    end
    tick();
    tick();
    m_valid = 1'b1;
    dones = 0;
    for (int i = 0; i < vlen + 4; i++) begin
      if (i == vlen) m_valid = 1'b0;
      tick();
      if (done !== 4'b0) begin
        dones++;
        n_chk++;
        if (done !== exp) begin
          n_fail++; $display("FAIL %s_done: got %b expected %b", name, done, exp);
        end
        n_chk++;
        if (cyc - last_done < 2) begin
          n_fail++; $display("FAIL %s_spacing: got %0d expected >=2", name, cyc - last_done);
        end
        last_done = cyc;
        req = req_after;
      end
    end
    n_chk++;
    if (dones != 1) begin
      n_fail++; $display("FAIL %s_done_count: got %0d expected 1", name, dones);
    end
    n_chk++;
    if (gnt !== 4'b0) begin
      n_fail++; $display("FAIL %s_gnt_release: got %b expected 0000", name, gnt);
    end
    m_state = 4'd0;
    tick();
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL %s_busy_idle: got %b expected 0", name, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_chk++;
    if ({gnt, done, err, busy, m_ena} !== 14'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %h expected 0", {gnt, done, err, busy, m_ena});
    end
    n_chk++;
    if ({m_rw, m_addr, m_nbyte} !== 13'b0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", {m_rw, m_addr, m_nbyte});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int ena_cnt;
    int early;
    req_addr  = {7'h33, 7'h22, 7'h50, 7'h11};
    req_nbyte = {5'd9, 5'd7, 5'd3, 5'd1};
    req_rw    = 4'b1101;
    req = 4'b0010;
    tick();
    n_chk++;
    if (gnt !== 4'b0010) begin
      n_fail++; $display("FAIL single_gnt: got %b expected 0010", gnt);
    end
    n_chk++;
    if ({m_rw, m_addr, m_nbyte} !== {1'b0, 7'h50, 5'd3}) begin
      n_fail++; $display("FAIL single_desc: got %b/%h/%0d expected 0/50/3", m_rw, m_addr, m_nbyte);
    end
    ena_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      if (m_ena === 1'b1) ena_cnt++;
      if (i == 3) m_state = 4'd3;
      tick();
    end
    n_chk++;
    if (ena_cnt != 4) begin
      n_fail++; $display("FAIL single_ena_len: got %0d expected 4", ena_cnt);
    end
    req_addr[13:7] = 7'h7f;
    early = 0;
    for (int i = 0; i < WAIT_CYC; i++) begin
      if (done !== 4'b0) early++;
      tick();
    end
    n_chk++;
    if (early != 0) begin
      n_fail++; $display("FAIL single_early_done: got %0d expected 0", early);
    end
    m_valid = 1'b1;
    tick();
    n_chk++;
    if ({done, gnt} !== {4'b0010, 4'b0000}) begin
      n_fail++; $display("FAIL single_done: got %b/%b expected 0010/0000", done, gnt);
    end
    n_chk++;
    if (m_addr !== 7'h50) begin
      n_fail++; $display("FAIL single_addr_hold: got %h expected 50", m_addr);
    end
    m_valid = 1'b0;
    req = 4'b0;
    tick();
    n_chk++;
    if ({done, busy} !== {4'b0000, 1'b1}) begin
      n_fail++; $display("FAIL single_release: got %b/%b expected 0000/1", done, busy);
    end
    m_state = 4'd0;
    tick();
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL single_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_simultaneous();
    rst_n = 1'b0;
    req = 4'b1011;
    tick();
    rst_n = 1'b1;
    run_txn(4'b0001, 1, 4'b1011, "rr0");
    run_txn(4'b0010, 1, 4'b1011, "rr1");
    run_txn(4'b1000, 1, 4'b1011, "rr3");
    run_txn(4'b0001, 1, 4'b0000, "rr0b");
  endtask

  task automatic test_master_busy();
    m_state = 4'd5;
    req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if (gnt !== 4'b0) begin
        n_fail++; $display("FAIL mbusy_hold: got %b expected 0000", gnt);
      end
    end
    m_state = 4'd0;
    tick();
    n_chk++;
    if (gnt !== 4'b0100) begin
      n_fail++; $display("FAIL mbusy_gnt: got %b expected 0100", gnt);
    end
    run_txn(4'b0100, 1, 4'b0000, "mbusy");
  endtask

  task automatic test_reset_mid();
    req = 4'b1000;
    tick();
    n_chk++;
    if (gnt !== 4'b1000) begin
      n_fail++; $display("FAIL rstmid_gnt: got %b expected 1000", gnt);
    end
    m_state = 4'd1;
    tick();
    tick();
    rst_n = 1'b0;
    m_state = 4'd0;
    #1;
    n_chk++;
    if ({gnt, m_ena, done, err, busy} !== 14'b0) begin
      n_fail++; $display("FAIL rstmid_clear: got %h expected 0", {gnt, m_ena, done, err, busy});
    end
    tick();
    rst_n = 1'b1;
    req = 4'b1001;
    run_txn(4'b0001, 1, 4'b0000, "rstmid_ptr");
  endtask

  task automatic test_glitch();
    int spurious;
    req = 4'b0001;
    run_txn(4'b0001, 5, 4'b0000, "glitch");
    tick();
    m_valid = 1'b1;
    spurious = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) m_valid = 1'b0;
      tick();
      if (done !== 4'b0 || busy !== 1'b0) spurious++;
    end
    n_chk++;
    if (spurious != 0) begin
      n_fail++; $display("FAIL idle_valid: got %0d spurious cycles expected 0", spurious);
    end
  endtask

`ifdef I2C_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int g_cyc;
    int n;
    req = 4'b0010;
    tick();
    g_cyc = cyc;
    m_state = 4'd1;
    n = 0;
    while (err === 4'b0 && n < 300) begin tick(); n++; end
    n_chk++;
    if (err !== 4'b0010) begin
      n_fail++; $display("FAIL tmo_err: got %b expected 0010", err);
    end
    n_chk++;
    if (cyc - g_cyc != TB_TO + 1) begin
      n_fail++; $display("FAIL tmo_time: got %0d expected %0d", cyc - g_cyc, TB_TO + 1);
    end
    n_chk++;
    if ({done, gnt, m_ena} !== 9'b0) begin
      n_fail++; $display("FAIL tmo_outs: got %h expected 0", {done, gnt, m_ena});
    end
    req = 4'b1000;
    m_state = 4'd0;
    tick();
    tick();
    n_chk++;
    if (gnt !== 4'b1000) begin
      n_fail++; $display("FAIL tmo_next: got %b expected 1000", gnt);
    end
    run_txn(4'b1000, 1, 4'b0000, "tmo_next");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_master_busy();
    test_reset_mid();
    test_glitch();
`ifdef I2C_ARB_TIMEOUT_EN
    test_timeout();
`else
    n_chk++;
    if (err_seen != 0) begin
      n_fail++; $display("FAIL err_tied: got %0d err cycles expected 0", err_seen);
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
